// File: rtl/ps2_mouse_painter.sv
// PS/2 mouse packet assembler with a saturating 6-bit cursor and palette painter for the 64x64 panel.
// Optional inter-byte resync timeout: define MOUSE_TIMEOUT_EN.
module ps2_mouse_painter #(
  parameter int SCALE_SHIFT    = 0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        mouse_data_valid,
  output logic [11:0] write_addr,
  output logic [11:0] write_data,
  output logic [5:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic [11:0] color
);

  typedef enum logic [2:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE, WRITE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit gap counter");
  end

  state_t      state_q, state_d;
  // byte0 fields kept: {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [5:0]  b0_q, b0_d;
  logic [7:0]  dx_q, dx_d, dy_q, dy_d;
  logic [5:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  cidx_q, cidx_d;
  logic        prev_right_q, prev_right_d;
  logic        mdv_q, mdv_d;
  logic [11:0] waddr_q, waddr_d, wdata_q, wdata_d;

  logic              sync_ok;
  logic              tmo_hit;
  logic signed [9:0] dx_s, dy_s, x_sum, y_sum;
  logic [5:0]        x_new, y_new;
  logic [2:0]        cidx_new;

  function automatic logic signed [9:0] delta(input logic sign, input logic [7:0] mag,
                                              input logic ovf);
    logic signed [9:0] ext;
    ext = {sign, sign, mag};
    if (ovf) return 10'sd0;
    return ext >>> SCALE_SHIFT;
  endfunction

  function automatic logic [5:0] sat6(input logic signed [9:0] v);
    if (v < 10'sd0)  return 6'd0;
    if (v > 10'sd63) return 6'd63;
    return v[5:0];
  endfunction

  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hF00;
      3'd1:    c = 12'h0F0;
      3'd2:    c = 12'h00F;
      3'd3:    c = 12'hFF0;
      3'd4:    c = 12'h0FF;
      3'd5:    c = 12'hF0F;
      3'd6:    c = 12'hFFF;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  assign sync_ok  = rx_valid && rx_byte[3];
  assign dx_s     = delta(b0_q[2], dx_q, b0_q[4]);
  assign dy_s     = delta(b0_q[3], dy_q, b0_q[5]);
  // PS/2 +Y points up while panel row 0 is the top, hence the subtraction
  assign x_sum    = $signed({4'b0000, x_q}) + dx_s;
  assign y_sum    = $signed({4'b0000, y_q}) - dy_s;
  assign x_new    = sat6(x_sum);
  assign y_new    = sat6(y_sum);
  assign cidx_new = (b0_q[1] && !prev_right_q) ? cidx_q + 3'd1 : cidx_q;

`ifdef MOUSE_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES));

  // Counter runs only while parked mid-packet; any state change (accepted byte or resync) clears it
  always_comb begin
    tmo_d = '0;
    if ((state_q == WAIT_B1 || state_q == WAIT_B2) && state_d == state_q && !tmo_hit)
      tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    b0_d         = b0_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    x_d          = x_q;
    y_d          = y_q;
    cidx_d       = cidx_q;
    prev_right_d = prev_right_q;
    mdv_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      WAIT_B0: begin
        if (sync_ok) begin
          b0_d    = {rx_byte[7:4], rx_byte[1:0]};
          state_d = WAIT_B1;
        end
      end
      WAIT_B1, WAIT_B2: begin
        if (tmo_hit) begin
          // a byte landing on the timeout cycle is judged as a fresh byte0
          state_d = WAIT_B0;
          if (sync_ok) begin
            b0_d    = {rx_byte[7:4], rx_byte[1:0]};
            state_d = WAIT_B1;
          end
        end else if (rx_valid) begin
          if (state_q == WAIT_B1) begin
            dx_d    = rx_byte;
            state_d = WAIT_B2;
          end else begin
            dy_d    = rx_byte;
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        x_d          = x_new;
        y_d          = y_new;
        cidx_d       = cidx_new;
        prev_right_d = b0_q[1];
        mdv_d        = b0_q[0];
        if (b0_q[0]) begin
          waddr_d = {y_new, x_new};
          wdata_d = palette(cidx_new);
        end
        state_d = WRITE;
      end
      WRITE:   state_d = WAIT_B0;
      default: state_d = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= WAIT_B0;
      b0_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      x_q          <= 6'd32;
      y_q          <= 6'd32;
      cidx_q       <= '0;
      prev_right_q <= 1'b0;
      mdv_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      b0_q         <= b0_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cidx_q       <= cidx_d;
      prev_right_q <= prev_right_d;
      mdv_q        <= mdv_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign mouse_data_valid = mdv_q;
  assign write_addr       = waddr_q;
  assign write_data       = wdata_q;
  assign cursor_x         = x_q;
  assign cursor_y         = y_q;
  assign color            = palette(cidx_q);

endmodule

// File: tb/tb_ps2_mouse_painter.sv
// Bench for ps2_mouse_painter: directed vector table, corner-case sequences and random packets vs. a model.
module tb_ps2_mouse_painter;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mouse_data_valid;
  logic [11:0] write_addr, write_data, color;
  logic [5:0]  cursor_x, cursor_y;

  ps2_mouse_painter #(.SCALE_SHIFT(0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .mouse_data_valid(mouse_data_valid), .write_addr(write_addr), .write_data(write_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .color(color)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          mx, my, midx;
  bit          mprev;
  logic [11:0] pal [8];

  function automatic int axis(input logic [7:0] b0, input logic [7:0] d, input bit is_y);
    int v;
    v = int'(d);
    if (is_y ? b0[5] : b0[4]) v -= 256;
    if (is_y ? b0[7] : b0[6]) v = 0;
    return v;
  endfunction

  function automatic int clamp63(input int v);
    return (v < 0) ? 0 : ((v > 63) ? 63 : v);
  endfunction

  task automatic model_reset();
    mx = 32; my = 32; midx = 0; mprev = 0;
  endtask

  task automatic model_packet(input logic [7:0] b0, b1, b2, output int nstb,
                              output logic [11:0] eaddr, output logic [11:0] edata);
    mx = clamp63(mx + axis(b0, b1, 0));
    my = clamp63(my - axis(b0, b2, 1));
    if (b0[1] && !mprev) midx = (midx + 1) % 8;
    mprev = b0[1];
    nstb  = b0[0] ? 1 : 0;
    eaddr = 12'(my * 64 + mx);
    edata = pal[midx];
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Observes the three cycles following the third byte; strobe expected in the second one
  task automatic run_packet(input logic [7:0] b0, b1, b2, input bit inject, output int nstb,
                            output int stb_cycle, output logic [11:0] a, output logic [11:0] d);
    send_byte(b0); gap(); send_byte(b1); gap(); send_byte(b2);
    nstb = 0; stb_cycle = -1; a = '0; d = '0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      if (mouse_data_valid) begin
        nstb++; stb_cycle = k; a = write_addr; d = write_data;
      end
      if (inject && k < 3) begin rx_byte = 8'h18; rx_valid = 1'b1; end
      else rx_valid = 1'b0;
    end
  endtask

  task automatic check_packet(input string tag, input logic [7:0] b0, b1, b2, input bit inject,
                              input int ex, ey, input logic [11:0] ecol, input int enstb,
                              input logic [11:0] eaddr, input logic [11:0] edata);
    int nstb, cyc;
    logic [11:0] a, d;
    run_packet(b0, b1, b2, inject, nstb, cyc, a, d);
    check({tag, " cursor_x"}, cursor_x, ex);
    check({tag, " cursor_y"}, cursor_y, ey);
    check({tag, " color"}, color, ecol);
    check({tag, " strobes"}, nstb, enstb);
    if (enstb == 1) begin
      check({tag, " strobe_cycle"}, cyc, 2);
      check({tag, " write_addr"}, a, eaddr);
      check({tag, " write_data"}, d, edata);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " x"}, cursor_x, 32);
    check({tag, " y"}, cursor_y, 32);
    check({tag, " color"}, color, 12'hF00);
    check({tag, " mdv"}, mouse_data_valid, 0);
    check({tag, " addr"}, write_addr, 0);
    check({tag, " data"}, write_data, 0);
  endtask

  typedef struct {
    bit          rst_b;
    logic [7:0]  b0, b1, b2;
    int          ex, ey;
    logic [11:0] ecol;
    int          nstb;
    logic [11:0] eaddr, edata;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstb;
    logic [11:0] ea, ed;
    logic [7:0] r0, r1, r2;

    pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F; pal[3] = 12'hFF0;
    pal[4] = 12'h0FF; pal[5] = 12'hF0F; pal[6] = 12'hFFF; pal[7] = 12'h000;

    vecs[0]  = '{0, 8'h08, 8'h05, 8'h00, 37, 32, 12'hF00, 0, 12'h000, 12'h000};
    vecs[1]  = '{1, 8'h29, 8'h01, 8'hFF, 33, 33, 12'hF00, 1, 12'h861, 12'hF00};
    vecs[2]  = '{0, 8'h08, 8'h7F, 8'h00, 63, 33, 12'hF00, 0, 12'h000, 12'h000};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = vecs[2];
    vecs[6]  = '{0, 8'h18, 8'h80, 8'h00, 0, 33, 12'hF00, 0, 12'h000, 12'h000};
    vecs[7]  = vecs[6];
    vecs[8]  = '{0, 8'h0A, 8'h00, 8'h00, 0, 33, 12'h0F0, 0, 12'h000, 12'h000};
    vecs[9]  = vecs[8];
    vecs[10] = '{0, 8'h08, 8'h00, 8'h00, 0, 33, 12'h0F0, 0, 12'h000, 12'h000};
    vecs[11] = '{0, 8'h0A, 8'h00, 8'h00, 0, 33, 12'h00F, 0, 12'h000, 12'h000};
    vecs[12] = '{0, 8'h48, 8'h10, 8'h00, 0, 33, 12'h00F, 0, 12'h000, 12'h000};
    vecs[13] = '{0, 8'h88, 8'h00, 8'h10, 0, 33, 12'h00F, 0, 12'h000, 12'h000};
    vecs[14] = '{0, 8'h28, 8'h00, 8'h80, 0, 63, 12'h00F, 0, 12'h000, 12'h000};
    vecs[15] = '{0, 8'h08, 8'h00, 8'h7F, 0, 0,  12'h00F, 0, 12'h000, 12'h000};
    vecs[16] = '{0, 8'h0B, 8'h02, 8'h00, 2, 0,  12'hFF0, 1, 12'h002, 12'hFF0};
    vecs[17] = '{0, 8'h09, 8'h05, 8'h01, 7, 0,  12'hFF0, 1, 12'h007, 12'hFF0};
    vecs[18] = '{0, 8'h0B, 8'h3F, 8'hFB, 63, 0, 12'h0FF, 1, 12'h03F, 12'h0FF};
    vecs[19] = '{0, 8'h39, 8'hFF, 8'hFF, 62, 1, 12'h0FF, 1, 12'h07E, 12'h0FF};

    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rst_b) do_reset();
      model_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2, nstb, ea, ed);
      check_packet($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2, 1'b0,
                   vecs[i].ex, vecs[i].ey, vecs[i].ecol, vecs[i].nstb, vecs[i].eaddr, vecs[i].edata);
    end

    // Bytes during UPDATE/WRITE must be ignored
    model_packet(8'h18, 8'hFF, 8'h00, nstb, ea, ed);
    check_packet("inject", 8'h18, 8'hFF, 8'h00, 1'b1, mx, my, pal[midx], nstb, ea, ed);
    model_packet(8'h18, 8'hFF, 8'h00, nstb, ea, ed);
    check_packet("after_inject", 8'h18, 8'hFF, 8'h00, 1'b0, 60, 1, 12'h0FF, nstb, ea, ed);

    // Bytes without sync bit at idle are discarded
    send_byte(8'h00);
    send_byte(8'h07);
    check_packet("resync", 8'h08, 8'h01, 8'h00, 1'b0, 61, 1, 12'h0FF, 0, 12'h000, 12'h000);
    mx = 61;

    // Reset in the middle of a packet
    send_byte(8'h08);
    send_byte(8'h05);
    do_reset();
    check_reset_state("midreset");
    check_packet("post_reset", 8'h08, 8'h01, 8'h00, 1'b0, 33, 32, 12'hF00, 0, 12'h000, 12'h000);
    mx = 33;

    // Random packets against the model, with occasional garbage bytes at idle
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom) & 8'hF7);
      r0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 3) != 0) r0 = r0 & 8'h3F;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      model_packet(r0, r1, r2, nstb, ea, ed);
      check_packet($sformatf("rand%0d", i), r0, r1, r2, 1'b0, mx, my, pal[midx], nstb, ea, ed);
    end

`ifdef MOUSE_TIMEOUT_EN
    send_byte(8'h08);
    send_byte(8'h02);
    repeat (TMO + 5) @(negedge clk);
    model_packet(8'h08, 8'h01, 8'h00, nstb, ea, ed);
    check_packet("timeout", 8'h08, 8'h01, 8'h00, 1'b0, mx, my, pal[midx], nstb, ea, ed);
`else
    send_byte(8'h08);
    send_byte(8'h02);
    repeat (TMO + 5) @(negedge clk);
    model_packet(8'h08, 8'h02, 8'h00, nstb, ea, ed);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("no_timeout cursor_x", cursor_x, mx);
    check("no_timeout cursor_y", cursor_y, my);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
